// File: rtl/riscv_pkg.sv
// Constants shared by the fetch stage and the jump control unit.
package riscv_pkg;

  typedef enum logic [1:0] {
    PC_SEL_PLUS4  = 2'b00,
    PC_SEL_BRANCH = 2'b01,
    PC_SEL_JUMP   = 2'b10,
    PC_SEL_RSVD   = 2'b11
  } pc_sel_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry hold buffer for an instruction that returns while the ID stage is stalled.
module fetch_skid_buf
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clear,
  input  logic            load,
  input  logic            drain,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            hold_v,
  output logic [31:0]     hold_instr,
  output logic [XLEN-1:0] hold_pc
);

  // A redirect clears the entry even if a load or drain is requested in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_v     <= 1'b0;
      hold_instr <= NOP_INSTR;
      hold_pc    <= '0;
    end else if (clear) begin
      hold_v <= 1'b0;
    end else if (load) begin
      hold_v     <= 1'b1;
      hold_instr <= in_instr;
      hold_pc    <= in_pc;
    end else if (drain) begin
      hold_v <= 1'b0;
    end
  end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction fetch: owns the PC, talks to instruction memory and fills the IF/ID register.
module if_fetch_stage
  import riscv_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            flush,
  input  logic [1:0]      pc_sel,
  input  logic [XLEN-1:0] branch_target,
  input  logic [XLEN-1:0] jump_target,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  output logic            id_valid,
  output logic [31:0]     id_instr,
  output logic [XLEN-1:0] id_pc,
  output logic [XLEN-1:0] id_pc_plus4
);

  localparam logic [XLEN-1:0] PC_STEP    = XLEN'(4);
  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] req_pc;
  logic            os;
  logic            drop;

  logic            hold_v;
  logic [31:0]     hold_instr;
  logic [XLEN-1:0] hold_pc;

  logic            accept;
  logic            fire;
  logic            resp;
  logic            live;
  logic [31:0]     src_instr;
  logic [XLEN-1:0] src_pc;

  assign accept    = !stall && !flush;
  assign imem_req  = !rst && !flush && !hold_v && (!os || (imem_rvalid && accept));
  assign imem_addr = pc;
  assign fire      = imem_req && imem_gnt;
  assign resp      = os && imem_rvalid;
  assign live      = resp && !drop && !flush;
  assign src_instr = hold_v ? hold_instr : imem_rdata;
  assign src_pc    = hold_v ? hold_pc : req_pc;

  fetch_skid_buf #(
    .XLEN(XLEN)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .clear     (flush),
    .load      (live && stall),
    .drain     (hold_v && accept),
    .in_instr  (imem_rdata),
    .in_pc     (req_pc),
    .hold_v    (hold_v),
    .hold_instr(hold_instr),
    .hold_pc   (hold_pc)
  );

  // A fetch still outstanding at a redirect stays outstanding but is marked for dropping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc     <= RESET_PC;
      req_pc <= '0;
      os     <= 1'b0;
      drop   <= 1'b0;
    end else if (flush) begin
      os   <= os && !imem_rvalid;
      drop <= os && !imem_rvalid;
      case (pc_sel_e'(pc_sel))
        PC_SEL_BRANCH: pc <= branch_target & ALIGN_MASK;
        PC_SEL_JUMP:   pc <= jump_target & ALIGN_MASK;
        default:       pc <= pc;
      endcase
    end else begin
      if (fire) begin
        req_pc <= pc;
        pc     <= pc + PC_STEP;
        os     <= 1'b1;
      end else if (resp) begin
        os <= 1'b0;
      end
      if (resp) begin
        drop <= 1'b0;
      end
    end
  end

  // The hold buffer drains ahead of any fresh response; otherwise an idle accept is a bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      id_valid    <= 1'b0;
      id_instr    <= NOP_INSTR;
      id_pc       <= '0;
      id_pc_plus4 <= '0;
    end else if (flush) begin
      id_valid <= 1'b0;
    end else if (!stall) begin
      if (hold_v || live) begin
        id_valid    <= 1'b1;
        id_instr    <= src_instr;
        id_pc       <= src_pc;
        id_pc_plus4 <= src_pc + PC_STEP;
      end else begin
        id_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Self-checking bench for if_fetch_stage: directed vector table, reset sequence, random run vs model.
module tb_if_fetch_stage;

  localparam logic [31:0] RST_PC = 32'h0000_0100;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        flush;
  logic [1:0]  pc_sel;
  logic [31:0] branch_target;
  logic [31:0] jump_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [31:0] id_pc_plus4;

  int total;
  int bad;

  typedef struct {
    logic        st;
    logic        fl;
    logic [1:0]  sel;
    logic [31:0] bt;
    logic [31:0] jt;
    logic        gnt;
    logic        rv;
    logic [31:0] rd;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_idv;
    logic        chk_id;
    logic [31:0] exp_instr;
    logic [31:0] exp_idpc;
  } vec_t;

  typedef struct packed {
    logic [31:0] pc;
    logic        dead;
  } flight_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } held_t;

  vec_t vecs[$];

  if_fetch_stage #(
    .XLEN    (32),
    .RESET_PC(RST_PC)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .flush        (flush),
    .pc_sel       (pc_sel),
    .branch_target(branch_target),
    .jump_target  (jump_target),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_gnt     (imem_gnt),
    .imem_rvalid  (imem_rvalid),
    .imem_rdata   (imem_rdata),
    .id_valid     (id_valid),
    .id_instr     (id_instr),
    .id_pc        (id_pc),
    .id_pc_plus4  (id_pc_plus4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic st, input logic fl, input logic [1:0] sel,
                              input logic [31:0] bt, input logic [31:0] jt,
                              input logic gnt, input logic rv, input logic [31:0] rd,
                              input logic er, input logic [31:0] ea, input logic ev,
                              input logic ck, input logic [31:0] ei, input logic [31:0] ep);
    vec_t v;
    v.st = st; v.fl = fl; v.sel = sel; v.bt = bt; v.jt = jt;
    v.gnt = gnt; v.rv = rv; v.rd = rd;
    v.exp_req = er; v.exp_addr = ea; v.exp_idv = ev; v.chk_id = ck;
    v.exp_instr = ei; v.exp_idpc = ep;
    return v;
  endfunction

  task automatic applyStimulus(input vec_t v);
    stall         = v.st;
    flush         = v.fl;
    pc_sel        = v.sel;
    branch_target = v.bt;
    jump_target   = v.jt;
    imem_gnt      = v.gnt;
    imem_rvalid   = v.rv;
    imem_rdata    = v.rd;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected behaviour from the fetch rules, tracked as queues of in-flight and held fetches.
  logic [31:0] m_pc;
  flight_t     inflight[$];
  held_t       holdq[$];
  logic        m_idv;
  logic [31:0] m_instr;
  logic [31:0] m_idpc;

  function automatic logic model_req(input logic st, input logic fl, input logic rv);
    return !fl && (holdq.size() == 0) && ((inflight.size() == 0) || (rv && !st && !fl));
  endfunction

  task automatic modelReset();
    m_pc = RST_PC;
    inflight.delete();
    holdq.delete();
    m_idv = 1'b0;
    m_instr = NOP;
    m_idpc = 32'h0;
  endtask

  task automatic modelStep(input vec_t v);
    flight_t e;
    held_t   h;
    logic    got;
    logic    req;
    req = model_req(v.st, v.fl, v.rv);
    got = 1'b0;
    e = '0;
    if (v.rv && inflight.size() != 0) begin
      e = inflight.pop_front();
      got = !e.dead && !v.fl;
    end
    if (v.fl) begin
      m_idv = 1'b0;
      holdq.delete();
      foreach (inflight[k]) inflight[k].dead = 1'b1;
      if (v.sel == 2'b01) m_pc = {v.bt[31:2], 2'b00};
      else if (v.sel == 2'b10) m_pc = {v.jt[31:2], 2'b00};
    end else begin
      if (req && v.gnt) begin
        inflight.push_back('{pc: m_pc, dead: 1'b0});
        m_pc = m_pc + 32'd4;
      end
      if (!v.st) begin
        if (holdq.size() != 0) begin
          h = holdq.pop_front();
          m_idv = 1'b1; m_instr = h.instr; m_idpc = h.pc;
        end else if (got) begin
          m_idv = 1'b1; m_instr = v.rd; m_idpc = e.pc;
        end else begin
          m_idv = 1'b0;
        end
      end else if (got) begin
        holdq.push_back('{instr: v.rd, pc: e.pc});
      end
    end
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b1;
    applyStimulus(mk(0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    vec_t v;
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    applyStimulus(mk(0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    #12;
    checkOutput("rst_req", imem_req, 0);
    checkOutput("rst_addr", imem_addr, RST_PC);
    checkOutput("rst_idv", id_valid, 0);
    checkOutput("rst_instr", id_instr, NOP);
    checkOutput("rst_idpc", id_pc, 0);
    checkOutput("rst_pc4", id_pc_plus4, 0);

    // Startup, stall with held response, gnt gaps, flushes and reserved select.
    vecs.push_back(mk(0,0,0,0,0, 1,0,0,            1,32'h100, 0,0,0,0));
    vecs.push_back(mk(0,0,0,0,0, 1,1,32'hA000_0000, 1,32'h104, 1,1,32'hA000_0000,32'h100));
    vecs.push_back(mk(0,0,0,0,0, 1,1,32'hA000_0001, 1,32'h108, 1,1,32'hA000_0001,32'h104));
    vecs.push_back(mk(1,0,0,0,0, 1,1,32'hA000_0002, 0,32'h10C, 1,1,32'hA000_0001,32'h104));
    vecs.push_back(mk(1,0,0,0,0, 1,0,0,            0,32'h10C, 1,1,32'hA000_0001,32'h104));
    vecs.push_back(mk(1,0,0,0,0, 1,0,0,            0,32'h10C, 1,1,32'hA000_0001,32'h104));
    vecs.push_back(mk(0,0,0,0,0, 1,0,0,            0,32'h10C, 1,1,32'hA000_0002,32'h108));
    vecs.push_back(mk(0,0,0,0,0, 1,0,0,            1,32'h10C, 0,0,0,0));
    vecs.push_back(mk(0,0,0,0,0, 0,1,32'hA000_0003, 1,32'h110, 1,1,32'hA000_0003,32'h10C));
    for (int i = 0; i < 3; i++)
      vecs.push_back(mk(0,0,0,0,0, 0,0,0,          1,32'h110, 0,0,0,0));
    vecs.push_back(mk(0,0,0,0,0, 1,0,0,            1,32'h110, 0,0,0,0));
    vecs.push_back(mk(0,1,2'b01,32'h200,0, 1,0,0,  0,32'h114, 0,0,0,0));
    vecs.push_back(mk(0,0,0,0,0, 1,1,32'hDEAD_BEEF, 1,32'h200, 0,0,0,0));
    vecs.push_back(mk(0,0,0,0,0, 1,1,32'hA000_0004, 1,32'h204, 1,1,32'hA000_0004,32'h200));
    vecs.push_back(mk(1,0,0,0,0, 1,1,32'hA000_0005, 0,32'h208, 1,1,32'hA000_0004,32'h200));
    vecs.push_back(mk(1,1,2'b10,0,32'h3FE, 1,0,0,  0,32'h208, 0,0,0,0));
    vecs.push_back(mk(0,0,0,0,0, 1,0,0,            1,32'h3FC, 0,0,0,0));
    vecs.push_back(mk(0,0,0,0,0, 0,1,32'hA000_0006, 1,32'h400, 1,1,32'hA000_0006,32'h3FC));
    vecs.push_back(mk(0,1,2'b11,32'h500,32'h600, 1,0,0, 0,32'h400, 0,0,0,0));
    vecs.push_back(mk(0,0,0,0,0, 1,0,0,            1,32'h400, 0,0,0,0));

    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      #1;
      checkOutput($sformatf("vec%0d_req", i), imem_req, vecs[i].exp_req);
      checkOutput($sformatf("vec%0d_addr", i), imem_addr, vecs[i].exp_addr);
      @(posedge clk);
      #1;
      checkOutput($sformatf("vec%0d_idv", i), id_valid, vecs[i].exp_idv);
      if (vecs[i].chk_id) begin
        checkOutput($sformatf("vec%0d_instr", i), id_instr, vecs[i].exp_instr);
        checkOutput($sformatf("vec%0d_idpc", i), id_pc, vecs[i].exp_idpc);
        checkOutput($sformatf("vec%0d_pc4", i), id_pc_plus4, vecs[i].exp_idpc + 32'd4);
      end
      @(negedge clk);
    end

    // Reset while a fetch is outstanding, then a stray response right after release.
    applyStimulus(mk(0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    rst = 1'b1;
    #1;
    checkOutput("midrst_req", imem_req, 0);
    checkOutput("midrst_addr", imem_addr, RST_PC);
    checkOutput("midrst_idv", id_valid, 0);
    checkOutput("midrst_instr", id_instr, NOP);
    checkOutput("midrst_idpc", id_pc, 0);
    checkOutput("midrst_pc4", id_pc_plus4, 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(mk(0, 0, 2'b00, 0, 0, 0, 1, 32'hBAD0_BAD0, 0, 0, 0, 0, 0, 0));
    #1;
    checkOutput("stray_req", imem_req, 1);
    checkOutput("stray_addr", imem_addr, RST_PC);
    @(posedge clk);
    #1;
    checkOutput("stray_idv", id_valid, 0);
    checkOutput("stray_instr", id_instr, NOP);

    // Random traffic against the reference model.
    doReset();
    modelReset();
    for (int c = 0; c < 3000; c++) begin
      v = mk($urandom_range(0, 4) == 0, $urandom_range(0, 7) == 0, 2'($urandom),
             $urandom, $urandom, $urandom_range(0, 3) != 0, 1'b0, $urandom,
             0, 0, 0, 0, 0, 0);
      v.rv = (inflight.size() != 0) ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 15) == 0);
      applyStimulus(v);
      #1;
      checkOutput($sformatf("rnd%0d_req", c), imem_req, model_req(v.st, v.fl, v.rv));
      checkOutput($sformatf("rnd%0d_addr", c), imem_addr, m_pc);
      modelStep(v);
      @(posedge clk);
      #1;
      checkOutput($sformatf("rnd%0d_idv", c), id_valid, m_idv);
      if (m_idv) begin
        checkOutput($sformatf("rnd%0d_instr", c), id_instr, m_instr);
        checkOutput($sformatf("rnd%0d_idpc", c), id_pc, m_idpc);
        checkOutput($sformatf("rnd%0d_pc4", c), id_pc_plus4, m_idpc + 32'd4);
      end
      @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
